fifo_read_streamer: RTL and testbench
=====================================

// Module: fifo_read_streamer
// PURPOSE
//  Read-side consumer for the asynchronous FIFO, running in the FIFO read domain.
//  Drives r_en against empty, captures the FIFO's registered data_out (1-cycle latency),
//  buffers it in a 3-entry skid buffer and presents a valid/ready stream with burst framing.
//  Sustains 1 word/cycle with no combinational path from m_ready to fifo_r_en.
// PARAMETERS
//  width      8   data word width; must match the FIFO width
//  BURST_LEN  4   beats per burst; m_last marks every BURST_LEN-th beat (>=1)
// PORTS
//  r_clk       in   1          read-domain clock; all logic on posedge
//  rst         in   1          asynchronous, active-high reset
//  fifo_empty  in   1          FIFO empty flag
//  fifo_data   in   width      FIFO data_out (registered inside the FIFO)
//  fifo_r_en   out  1          FIFO read enable
//  m_valid     out  1          stream word valid
//  m_ready     in   1          downstream accepts the word
//  m_data      out  width      stream word
//  m_last      out  1          final beat of the current burst
//  beat_cnt    out  CW         beats accepted in the current burst; CW=max(1,$clog2(BURST_LEN))
//  words_out   out  16         total accepted beats, wraps at 2^16
// BEHAVIOUR
//  Interface and reset:
//  - One clock, r_clk. Reset rst is asynchronous and active-high.
//  - Reset value of every output and register is 0. This includes buffer occupancy, the
//    in-flight flag, fifo_r_en, m_valid, m_data, m_last, beat_cnt and words_out.
//  Read issue:
//  - fifo_r_en = !fifo_empty && (occ + inflight) <= 2.
//  - fifo_r_en is combinational from fifo_empty and local registers only.
//  - inflight <= fifo_r_en each cycle.
//  Capture:
//  - In the cycle after a read is issued (inflight==1), fifo_data is written at the buffer tail.
//  - The FIFO holds data_out while it is not read, so capture happens only when inflight==1.
//  Buffer:
//  - 3-entry circular buffer with 2-bit rd_ptr and wr_ptr, each wrapping 2->0, and occ in 0..3.
//  - occ_next = occ + inflight - (m_valid && m_ready).
//  - A capture and a pop in the same cycle are both legal; occ is then unchanged.
//  - occ never exceeds 3 by construction. The bench asserts this.
//  Stream output:
//  - m_valid = (occ != 0). m_data = buf[rd_ptr]. Both are combinational from registers.
//  - Zero-latency pass-through is not provided. The first word appears 2 cycles after
//    fifo_r_en is first asserted: issue at T, capture at T+1, m_valid at T+2.
//  - While m_valid && !m_ready, m_data and m_last are held stable and m_valid stays high.
//  Framing:
//  - m_last = m_valid && (beat_cnt == BURST_LEN-1).
//  - On each handshake, beat_cnt increments, or clears to 0 when m_last is high.
//  - On each handshake, words_out increments.
//  - When BURST_LEN=1, m_last is high on every valid beat and beat_cnt stays at 0.
//  Boundaries:
//  - FIFO empty mid-stream: fifo_r_en drops. Buffered words still drain. m_valid falls
//    when occ reaches 0. beat_cnt is retained, so a burst can span gaps.
//  - Buffer full (occ + inflight == 3): fifo_r_en is held low until a pop occurs.
//  - fifo_empty rising in the same cycle as a read: that read is not issued.
//  - An already-issued read is still captured.
//  - Reset mid-operation: buffer contents, in-flight word and counters are discarded
//    immediately.
//  - rst is shared with the FIFO, so both ends restart empty. No partial burst survives reset.
// TESTING
//  1 Reset: assert rst mid-stream with occ=2 -> all outputs 0 asynchronously, before the next edge.
//  2 Single word: push 0xA5 into the FIFO, hold m_ready=1 -> fifo_r_en one cycle; m_valid
//    2 cycles later with m_data=0xA5 and m_last=0; words_out=1.
//  3 Throughput: 32 words preloaded, m_ready=1 -> after fill, m_valid is high every cycle;
//    words_out=32; data order matches write order.
//  4 Backpressure: 8 words preloaded, m_ready=0 -> exactly 3 fifo_r_en pulses; occ=3;
//    m_data stays at word0. Release m_ready -> words 0..7 delivered in order, none lost
//    or duplicated.
//  5 Framing, BURST_LEN=4: 10 words -> m_last on beats 3 and 7; beat_cnt ends at 2.
//  6 Gap: FIFO empties after 2 words, refill after 20 cycles -> m_valid drops.
//    beat_cnt holds 2. The next m_last occurs on the 4th beat overall.

Source files
------------

// File: rtl/fifo_read_streamer_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream for fifo_read_streamer.
// The master modport is the streamer; the slave side is the FIFO plus the downstream consumer.
interface fifo_read_streamer_if #(
    parameter int width     = 8,
    parameter int BURST_LEN = 4
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic             fifo_empty;
    logic [width-1:0] fifo_data;
    logic             fifo_r_en;
    logic             m_valid;
    logic             m_ready;
    logic [width-1:0] m_data;
    logic             m_last;
    logic [CW-1:0]    beat_cnt;
    logic [15:0]      words_out;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data, m_last, beat_cnt, words_out
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data, m_last, beat_cnt, words_out
    );
endinterface

// File: rtl/fifo_read_streamer.sv
// Read-domain consumer for the async FIFO: issues reads, captures the registered data_out
// into a 3-entry skid buffer and emits a burst-framed valid/ready stream at 1 word/cycle.
module fifo_read_streamer #(
    parameter int width     = 8,
    parameter int BURST_LEN = 4
) (
    input logic                 r_clk,
    input logic                 rst,
    fifo_read_streamer_if.master bus
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [width-1:0] buffer [0:2];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       occ;
    logic             inflight;
    logic [CW-1:0]    beat_q;
    logic [15:0]      words_q;

    logic             issue;
    logic             pop;
    logic             last;
    logic [1:0]       occ_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads are only issued when the word can be guaranteed a buffer slot, so the read
    // decision never looks at m_ready and the buffer can never overflow.
    assign issue    = !bus.fifo_empty && (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
    assign pop      = bus.m_valid && bus.m_ready;
    assign last     = bus.m_valid && (beat_q == LAST_BEAT);
    assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};

    assign bus.fifo_r_en = issue;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = buffer[rd_ptr];
    assign bus.m_last    = last;
    assign bus.beat_cnt  = beat_q;
    assign bus.words_out = words_q;

    // The FIFO presents data one cycle after r_en, so inflight marks the capture cycle.
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                buffer[i] <= '0;
            end
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            beat_q   <= '0;
            words_q  <= 16'd0;
        end else begin
            inflight <= issue;
            occ      <= occ_next;
            if (inflight) begin
                buffer[wr_ptr] <= bus.fifo_data;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                words_q <= words_q + 16'd1;
                beat_q  <= last ? '0 : beat_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench for fifo_read_streamer: a behavioural FIFO feeds directed words, and a
// monitor pops expected {data,last} pairs whenever the stream handshakes.
module tb_fifo_read_streamer;
    localparam int width     = 8;
    localparam int BURST_LEN = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic r_clk;
    logic rst;

    fifo_read_streamer_if #(.width(width), .BURST_LEN(BURST_LEN)) bus ();

    fifo_read_streamer #(.width(width), .BURST_LEN(BURST_LEN)) dut (
        .r_clk (r_clk),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t       exp_q[$];
    int         exp_beat = 0;

    logic [7:0] mem [0:255];
    logic [7:0] fifo_wr;
    logic [7:0] fifo_rd;

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Behavioural FIFO: registered data_out, held while not read, shares rst with the streamer.
    assign bus.fifo_empty = (fifo_wr == fifo_rd);
    always @(posedge r_clk or posedge rst) begin
        if (rst) begin
            fifo_rd       <= 8'd0;
            bus.fifo_data <= 8'd0;
        end else if (bus.fifo_r_en) begin
            bus.fifo_data <= mem[fifo_rd];
            fifo_rd       <= fifo_rd + 8'd1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        exp_t e;
        mem[fifo_wr] = word;
        fifo_wr      = fifo_wr + 8'd1;
        e.data       = word;
        e.last       = (exp_beat == BURST_LEN - 1);
        exp_beat     = e.last ? 0 : exp_beat + 1;
        exp_q.push_back(e);
    endtask

    task automatic doReset();
        @(negedge r_clk);
        rst     = 1'b1;
        fifo_wr = 8'd0;
        exp_q.delete();
        exp_beat = 0;
        @(negedge r_clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic waitWords(input int n, input int budget);
        int c;
        c = 0;
        while (int'(bus.words_out) != n && c < budget) begin
            @(negedge r_clk);
            c++;
        end
        checkOutput("words_out_wait", int'(bus.words_out), n);
    endtask

    task automatic countReads(input int cycles, output int ren_cnt, output int first_ren,
                              output int first_valid);
        ren_cnt     = 0;
        first_ren   = -1;
        first_valid = -1;
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (bus.fifo_r_en) begin
                ren_cnt++;
                if (first_ren < 0) first_ren = c;
            end
            if (bus.m_valid && first_valid < 0) first_valid = c;
            @(negedge r_clk);
        end
    endtask

    // Monitor: samples just after the falling edge, i.e. the values the next rising edge sees.
    int         mon_words = 0;
    int         mon_beat  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    initial begin
        forever begin
            exp_t e;
            @(negedge r_clk);
            #1;
            if (rst) begin
                mon_words  = 0;
                mon_beat   = 0;
                prev_stall = 1'b0;
            end else begin
                checkOutput("occ_bound", int'(({1'b0, dut.occ} + {2'b00, dut.inflight}) <= 3'd3), 1);
                if (prev_stall) begin
                    checkOutput("stall_valid", int'(bus.m_valid), 1);
                    checkOutput("stall_data", int'(bus.m_data), int'(prev_data));
                    checkOutput("stall_last", int'(bus.m_last), int'(prev_last));
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_word", int'(bus.m_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("sb_data", int'(bus.m_data), int'(e.data));
                        checkOutput("sb_last", int'(bus.m_last), int'(e.last));
                        checkOutput("sb_beat_cnt", int'(bus.beat_cnt), mon_beat);
                        checkOutput("sb_words_out", int'(bus.words_out), mon_words);
                        mon_words = (mon_words + 1) % 65536;
                        mon_beat  = e.last ? 0 : mon_beat + 1;
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
            end
        end
    end

    initial begin
        int ren_cnt, first_ren, first_valid;
        int started, total, hs;

        rst         = 1'b1;
        fifo_wr     = 8'd0;
        bus.m_ready = 1'b0;
        #3;
        checkOutput("rst_m_valid", int'(bus.m_valid), 0);
        checkOutput("rst_fifo_r_en", int'(bus.fifo_r_en), 0);
        checkOutput("rst_words_out", int'(bus.words_out), 0);
        checkOutput("rst_beat_cnt", int'(bus.beat_cnt), 0);
        @(negedge r_clk);
        #2;
        rst = 1'b0;

        $display("[TB] single word");
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        applyStimulus(8'hA5);
        countReads(8, ren_cnt, first_ren, first_valid);
        checkOutput("single_ren_pulses", ren_cnt, 1);
        checkOutput("single_latency", first_valid - first_ren, 2);
        checkOutput("single_words_out", int'(bus.words_out), 1);

        $display("[TB] throughput");
        doReset();
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 32; i++) applyStimulus(8'(i * 7 + 3));
        started = 0;
        total   = 0;
        hs      = 0;
        for (int c = 0; c < 200 && hs < 32; c++) begin
            #1;
            if (bus.m_valid) started = 1;
            if (started != 0) begin
                total++;
                if (bus.m_valid) hs++;
            end
            @(negedge r_clk);
        end
        checkOutput("thru_cycles", total, 32);
        checkOutput("thru_words_out", int'(bus.words_out), 32);

        $display("[TB] backpressure");
        doReset();
        @(negedge r_clk);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h40 + i));
        countReads(10, ren_cnt, first_ren, first_valid);
        #1;
        checkOutput("bp_ren_pulses", ren_cnt, 3);
        checkOutput("bp_occ", int'(dut.occ), 3);
        checkOutput("bp_hold_data", int'(bus.m_data), 8'h40);
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        waitWords(8, 60);
        checkOutput("bp_sb_empty", exp_q.size(), 0);

        $display("[TB] framing");
        doReset();
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h80 + i));
        waitWords(10, 80);
        checkOutput("frame_beat_cnt", int'(bus.beat_cnt), 2);

        $display("[TB] gap");
        doReset();
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (20) @(negedge r_clk);
        #1;
        checkOutput("gap_m_valid", int'(bus.m_valid), 0);
        checkOutput("gap_beat_cnt", int'(bus.beat_cnt), 2);
        @(negedge r_clk);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitWords(4, 40);
        checkOutput("gap_beat_wrap", int'(bus.beat_cnt), 0);

        $display("[TB] reset mid-stream");
        doReset();
        @(negedge r_clk);
        bus.m_ready = 1'b1;
        applyStimulus(8'h51);
        applyStimulus(8'h52);
        applyStimulus(8'h53);
        waitWords(3, 40);
        bus.m_ready = 1'b0;
        applyStimulus(8'h54);
        applyStimulus(8'h55);
        repeat (5) @(negedge r_clk);
        #1;
        checkOutput("mid_m_valid", int'(bus.m_valid), 1);
        checkOutput("mid_occ", int'(dut.occ), 2);
        @(posedge r_clk);
        #2;
        rst     = 1'b1;
        fifo_wr = 8'd0;
        #1;
        checkOutput("mid_rst_m_valid", int'(bus.m_valid), 0);
        checkOutput("mid_rst_m_data", int'(bus.m_data), 0);
        checkOutput("mid_rst_m_last", int'(bus.m_last), 0);
        checkOutput("mid_rst_beat_cnt", int'(bus.beat_cnt), 0);
        checkOutput("mid_rst_words_out", int'(bus.words_out), 0);
        checkOutput("mid_rst_fifo_r_en", int'(bus.fifo_r_en), 0);
        checkOutput("mid_rst_occ", int'(dut.occ), 0);
        checkOutput("mid_rst_inflight", int'(dut.inflight), 0);
        exp_q.delete();
        exp_beat = 0;
        @(negedge r_clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge r_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
